// File: rtl/mem_port_arb.sv
// mem_port_arb: round-robin / fixed-priority arbiter sharing one 4-word burst memory port among NREQ masters
//   clk, reset_l                         clock, synchronous active-low reset
//   cl_req/cl_gnt/cl_write               per-master request, one-cycle grant pulse, burst direction
//   cl_addr/cl_wr_data/cl_wr_par         per-master fields, master i at [i*W +: W]
//   cl_rd_data/cl_rd_par                 read word broadcast to every master, zero latency
//   mem_req/mem_gnt/mem_write/mem_addr   memory-side request handshake and owner's burst fields
//   mem_wr_data/mem_wr_par               owner's write word
//   mem_rd_data/mem_rd_par               read word from memory
module mem_port_arb #(
  parameter int NREQ      = 4,
  parameter int ADDRWIDTH = 29,
  parameter int DATAWIDTH = 64,
  parameter int PARWIDTH  = 8,
  parameter int BURSTLEN  = 4,
  parameter int FIXED_PRI = 0
) (
  input  logic                      clk,
  input  logic                      reset_l,
  input  logic [NREQ-1:0]           cl_req,
  output logic [NREQ-1:0]           cl_gnt,
  input  logic [NREQ-1:0]           cl_write,
  input  logic [NREQ*ADDRWIDTH-1:0] cl_addr,
  input  logic [NREQ*DATAWIDTH-1:0] cl_wr_data,
  input  logic [NREQ*PARWIDTH-1:0]  cl_wr_par,
  output logic [DATAWIDTH-1:0]      cl_rd_data,
  output logic [PARWIDTH-1:0]       cl_rd_par,
  output logic                      mem_req,
  input  logic                      mem_gnt,
  output logic                      mem_write,
  output logic [ADDRWIDTH-1:0]      mem_addr,
  output logic [DATAWIDTH-1:0]      mem_wr_data,
  output logic [PARWIDTH-1:0]       mem_wr_par,
  input  logic [DATAWIDTH-1:0]      mem_rd_data,
  input  logic [PARWIDTH-1:0]       mem_rd_par
);
  localparam int OW = $clog2(NREQ);
  localparam int BW = $clog2(BURSTLEN);
  typedef enum logic [1:0] {IDLE, REQ, BURST} state_t;
  state_t          r_state, w_state_nxt;
  logic [OW-1:0]   r_owner, w_owner_nxt, r_last, w_last_nxt, w_win;
  logic [BW-1:0]   r_beat, w_beat_nxt;
  // Search runs from the far end back toward the preferred slot so the
  // last match written is the winner: lowest index for fixed priority,
  // first slot after r_last for round robin.
  always_comb begin
    w_win = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (FIXED_PRI != 0) begin
        if (cl_req[k-1]) w_win = OW'(k-1);
      end else if (cl_req[(int'(r_last) + k) % NREQ]) begin
        w_win = OW'((int'(r_last) + k) % NREQ);
      end
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_beat_nxt  = r_beat;
    case (r_state)
      IDLE: if (|cl_req) begin
        w_state_nxt = REQ;
        w_owner_nxt = w_win;
      end
      REQ: if (mem_gnt) begin
        w_state_nxt = BURST;
        w_last_nxt  = r_owner;
        w_beat_nxt  = '0;
      end
      BURST: begin
        w_beat_nxt  = r_beat + BW'(1);
        w_state_nxt = (r_beat == BW'(BURSTLEN-1)) ? IDLE : BURST;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= OW'(NREQ-1);
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_beat  <= w_beat_nxt;
    end
  end
  assign mem_req     = (r_state == REQ);
  assign cl_gnt      = (r_state == REQ && mem_gnt) ? (NREQ'(1) << r_owner) : '0;
  assign mem_write   = cl_write[r_owner];
  assign mem_addr    = cl_addr[int'(r_owner)*ADDRWIDTH +: ADDRWIDTH];
  assign mem_wr_data = cl_wr_data[int'(r_owner)*DATAWIDTH +: DATAWIDTH];
  assign mem_wr_par  = cl_wr_par[int'(r_owner)*PARWIDTH +: PARWIDTH];
  assign cl_rd_data  = mem_rd_data;
  assign cl_rd_par   = mem_rd_par;
endmodule
